fm_hdmi_ycgen: RTL and testbench
================================

Name: fm_hdmi_ycgen

Overview:
- Video-clock pixel pipeline that converts 24-bit RGB plus sync/enable timing into 8-bit Y and 8-bit multiplexed Cb/Cr (BT.601 limited range, YCbCr 4:2:2).
- Feeds the HDMI DDR output stage directly: o_y drives that stage's Y input, o_c drives its C input.
- Delays the sync and enable signals so they stay aligned with the converted pixels.

Parameters:
- P_BLANK_Y, 8'h10, Y value driven while o_de=0.
- P_BLANK_C, 8'h80, C value driven while o_de=0.
- P_CLAMP, 1, 1: clamp Y to 16..235 and C to 16..240; 0: clamp only to 0..255.

Ports:
- clk_v  in  1  video pixel clock; the single clock of the block.
- rst_x  in  1  reset; synchronous, active-high.
- i_r  in  8  red component, unsigned.
- i_g  in  8  green component, unsigned.
- i_b  in  8  blue component, unsigned.
- i_de  in  1  data enable; pixel valid when 1.
- i_hs  in  1  hsync, polarity passed through.
- i_vs  in  1  vsync, polarity passed through.
- o_y  out  8  luma.
- o_c  out  8  chroma: Cb on even pixels, Cr on odd pixels.
- o_de  out  1  delayed i_de.
- o_hs  out  1  delayed i_hs.
- o_vs  out  1  delayed i_vs.

Behaviour:
- Only clk_v rising edges are used; every register is in the clk_v domain.
- Reset (rst_x=1 at a clock edge) clears all pipeline registers on that edge, including mid-line. Outputs after the reset edge:
  - o_y=P_BLANK_Y, o_c=P_BLANK_C.
  - o_de=0, o_hs=0, o_vs=0.
  - Chroma phase=even; Cr hold register=0x80.
- Fixed latency of 4 clocks from inputs to all outputs. No stalls, no backpressure, one pixel per clock.
- Pipeline stage S1: register the nine 8x8 unsigned products, coefficients 66,129,25 / 38,74,112 / 112,94,18.
- Pipeline stage S2: signed sums in 18-bit two's complement:
  - Ys = 66R + 129G + 25B + 128
  - Cbs = -38R - 74G + 112B + 128
  - Crs = 112R - 94G - 18B + 128
- Pipeline stage S3: arithmetic shift right by 8 (floor), add offsets (Y +16, Cb/Cr +128), then clamp per P_CLAMP.
- Pipeline stage S4: 4:2:2 selection.
  - Phase resets to even on the pixel where de rises (i_de 0->1 as seen at this stage), then toggles on every pixel with de=1.
  - Even pixel: o_c=Cb of this pixel; Cr of this pixel is captured into the hold register (co-sited sampling).
  - Odd pixel: o_c=hold register (Cr of the preceding even pixel); this pixel's own chroma is discarded.
  - o_y is always the Y of the current pixel.
- When the S4 de=0: o_y=P_BLANK_Y, o_c=P_BLANK_C, phase is held at even, hold register is unchanged.
- Odd-length line: the final even pixel outputs its Cb; its Cr is never emitted; the next line restarts at even.
- hs/vs pass through a 4-stage shift register with no modification. de changing on the same clock as hs/vs is allowed and stays aligned.
- A de gap of even one cycle inside a line restarts the phase at even.

Test Plan:
- Reset: hold rst_x=1 for 3 clocks with random inputs -> o_y=0x10, o_c=0x80, o_de/o_hs/o_vs=0 from the first edge after reset asserts. Deassert rst_x -> first valid pixel appears exactly 4 clocks after it is applied.
- Black/white: RGB (0,0,0) at de=1 -> o_y=16, o_c=128. RGB (255,255,255) -> o_y=235, o_c=128 on both phases.
- Red then blue pixel pair starting at the de rise (pixel0=(255,0,0), pixel1=(0,0,255)):
  - pixel0 -> o_y=82, o_c=90 (Cb of red).
  - pixel1 -> o_y=41, o_c=240 (Cr of red).
- Blue then red pair (pixel0=(0,0,255), pixel1=(255,0,0)):
  - pixel0 -> o_y=41, o_c=240 (Cb of blue).
  - pixel1 -> o_y=82, o_c=110 (Cr of blue).
- Timing alignment and phase restart:
  - 5-pixel line, 3 blanking clocks, then 4-pixel line, with hs pulsing during blanking -> o_de/o_hs reproduce the input pattern exactly 4 clocks later.
  - C order for the 5-pixel line is Cb,Cr,Cb,Cr,Cb; the second line starts with Cb.
  - o_y=0x10 and o_c=0x80 during blanking.
- Reset mid-line: assert rst_x at pixel 3 of a line -> outputs blank on the next edge, no stale pixel emerges later. Next de rise starts with Cb and the hold register reads 0x80 until the first even pixel is captured.

Source files
------------

// File: rtl/fm_hdmi_ycgen.sv
// fm_hdmi_ycgen: RGB888 to BT.601 limited-range YCbCr 4:2:2 pipeline, 4-clock latency,
// with de/hs/vs delayed to stay aligned with the converted pixels.
module fm_hdmi_ycgen #(
    parameter logic [7:0] P_BLANK_Y = 8'h10,
    parameter logic [7:0] P_BLANK_C = 8'h80,
    parameter bit         P_CLAMP   = 1'b1
) (
    input  logic       clk_v,
    input  logic       rst_x,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    input  logic       i_de,
    input  logic       i_hs,
    input  logic       i_vs,
    output logic [7:0] o_y,
    output logic [7:0] o_c,
    output logic       o_de,
    output logic       o_hs,
    output logic       o_vs
);
    localparam logic signed [17:0] L_Y_LO = P_CLAMP ? 18'sd16  : 18'sd0;
    localparam logic signed [17:0] L_Y_HI = P_CLAMP ? 18'sd235 : 18'sd255;
    localparam logic signed [17:0] L_C_LO = P_CLAMP ? 18'sd16  : 18'sd0;
    localparam logic signed [17:0] L_C_HI = P_CLAMP ? 18'sd240 : 18'sd255;

    logic        [15:0] r_p [0:8];
    logic signed [17:0] r_ys, r_cbs, r_crs;
    logic signed [17:0] w_y, w_cb, w_cr;
    logic        [7:0]  r_y3, r_cb3, r_cr3, r_cr_hold;
    logic        [2:0]  r_de, r_hs, r_vs;
    logic               r_odd;

    function automatic logic [7:0] f_clamp(input logic signed [17:0] v, lo, hi);
        return v < lo ? lo[7:0] : (v > hi ? hi[7:0] : v[7:0]);
    endfunction

    assign w_y  = (r_ys  >>> 8) + 18'sd16;
    assign w_cb = (r_cbs >>> 8) + 18'sd128;
    assign w_cr = (r_crs >>> 8) + 18'sd128;

    always_ff @(posedge clk_v) begin
        if (rst_x) begin
            for (int k = 0; k < 9; k++) r_p[k] <= '0;
            r_ys      <= '0;
            r_cbs     <= '0;
            r_crs     <= '0;
            r_y3      <= '0;
            r_cb3     <= '0;
            r_cr3     <= '0;
            r_cr_hold <= 8'h80;
            r_odd     <= 1'b0;
            r_de      <= '0;
            r_hs      <= '0;
            r_vs      <= '0;
            o_y       <= P_BLANK_Y;
            o_c       <= P_BLANK_C;
            o_de      <= 1'b0;
            o_hs      <= 1'b0;
            o_vs      <= 1'b0;
        end else begin
            r_p[0] <= {8'd0, i_r} * 16'd66;
            r_p[1] <= {8'd0, i_g} * 16'd129;
            r_p[2] <= {8'd0, i_b} * 16'd25;
            r_p[3] <= {8'd0, i_r} * 16'd38;
            r_p[4] <= {8'd0, i_g} * 16'd74;
            r_p[5] <= {8'd0, i_b} * 16'd112;
            r_p[6] <= {8'd0, i_r} * 16'd112;
            r_p[7] <= {8'd0, i_g} * 16'd94;
            r_p[8] <= {8'd0, i_b} * 16'd18;
            r_ys   <= {2'b0, r_p[0]} + {2'b0, r_p[1]} + {2'b0, r_p[2]} + 18'd128;
            r_cbs  <= {2'b0, r_p[5]} - {2'b0, r_p[3]} - {2'b0, r_p[4]} + 18'd128;
            r_crs  <= {2'b0, r_p[6]} - {2'b0, r_p[7]} - {2'b0, r_p[8]} + 18'd128;
            r_y3   <= f_clamp(w_y,  L_Y_LO, L_Y_HI);
            r_cb3  <= f_clamp(w_cb, L_C_LO, L_C_HI);
            r_cr3  <= f_clamp(w_cr, L_C_LO, L_C_HI);
            r_de   <= {r_de[1:0], i_de};
            r_hs   <= {r_hs[1:0], i_hs};
            r_vs   <= {r_vs[1:0], i_vs};
            o_de   <= r_de[2];
            o_hs   <= r_hs[2];
            o_vs   <= r_vs[2];
            // any de=0 cycle parks the phase at even, so each de rise starts with Cb
            if (r_de[2]) begin
                o_y   <= r_y3;
                o_c   <= r_odd ? r_cr_hold : r_cb3;
                r_odd <= ~r_odd;
                if (!r_odd) r_cr_hold <= r_cr3;
            end else begin
                o_y   <= P_BLANK_Y;
                o_c   <= P_BLANK_C;
                r_odd <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fm_hdmi_ycgen.sv
// tb_fm_hdmi_ycgen: directed vector table plus reset/latency/mid-line-reset sequences.
module tb_fm_hdmi_ycgen;
    logic       clk_v = 1'b0;
    logic       rst_x = 1'b1;
    logic [7:0] i_r = '0, i_g = '0, i_b = '0;
    logic       i_de = 1'b0, i_hs = 1'b0, i_vs = 1'b0;
    logic [7:0] o_y, o_c;
    logic       o_de, o_hs, o_vs;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        logic [7:0] r, g, b;
        logic       de, hs, vs;
        logic [7:0] y, c;
    } vec_t;
    vec_t vq[$];

    fm_hdmi_ycgen dut (
        .clk_v(clk_v), .rst_x(rst_x),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
        .o_y(o_y), .o_c(o_c), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs)
    );

    always #5 clk_v = ~clk_v;

    task automatic step(input logic [7:0] r, g, b, input logic de, hs, vs);
        i_r = r; i_g = g; i_b = b; i_de = de; i_hs = hs; i_vs = vs;
        @(posedge clk_v);
        #1;
    endtask

    task automatic idle();
        step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [7:0] y, c, input logic de, hs, vs);
        n_vec++;
        if (o_y !== y || o_c !== c || o_de !== de || o_hs !== hs || o_vs !== vs) begin
            n_err++;
            $display("FAIL %s: got y=%0d c=%0d de=%b hs=%b vs=%b, expected y=%0d c=%0d de=%b hs=%b vs=%b",
                     name, o_y, o_c, o_de, o_hs, o_vs, y, c, de, hs, vs);
        end
    endtask

    task automatic add(input logic [7:0] r, g, b, input logic de, hs, vs, input logic [7:0] y, c);
        vq.push_back('{r, g, b, de, hs, vs, y, c});
    endtask

    initial begin
        // Y/Cb/Cr: red 82/90/240, green 144/54/34, blue 41/240/110, black 16/128/128, white 235/128/128
        add(0, 0, 0, 0, 1, 0, 16, 128);
        add(0, 0, 0, 0, 0, 1, 16, 128);
        add(0, 0, 0, 1, 0, 0, 16, 128);
        add(0, 0, 0, 1, 0, 0, 16, 128);
        add(0, 0, 0, 0, 0, 0, 16, 128);
        add(255, 255, 255, 1, 0, 0, 235, 128);
        add(255, 255, 255, 1, 0, 0, 235, 128);
        add(0, 0, 0, 0, 0, 0, 16, 128);
        add(255, 0, 0, 1, 0, 0, 82, 90);
        add(0, 0, 255, 1, 0, 0, 41, 240);
        add(0, 0, 0, 0, 0, 0, 16, 128);
        add(0, 0, 255, 1, 0, 0, 41, 240);
        add(255, 0, 0, 1, 0, 0, 82, 110);
        add(0, 0, 0, 0, 1, 0, 16, 128);
        add(255, 0, 0, 1, 0, 0, 82, 90);
        add(0, 255, 0, 1, 0, 0, 144, 240);
        add(0, 0, 255, 1, 0, 0, 41, 240);
        add(255, 0, 0, 1, 0, 0, 82, 110);
        add(0, 255, 0, 1, 0, 0, 144, 54);
        add(0, 0, 0, 0, 0, 0, 16, 128);
        add(0, 0, 0, 0, 1, 0, 16, 128);
        add(0, 0, 0, 0, 0, 0, 16, 128);
        add(0, 0, 255, 1, 0, 0, 41, 240);
        add(0, 255, 0, 1, 0, 0, 144, 110);
        add(0, 255, 0, 1, 0, 0, 144, 54);
        add(255, 0, 0, 1, 0, 0, 82, 34);
        add(0, 0, 0, 0, 1, 1, 16, 128);
        add(255, 0, 0, 1, 0, 0, 82, 90);
        add(0, 0, 0, 0, 0, 0, 16, 128);
        add(0, 255, 0, 1, 0, 0, 144, 54);
        add(0, 0, 255, 1, 0, 0, 41, 34);
        add(0, 0, 0, 0, 0, 0, 16, 128);

        for (int i = 0; i < 3; i++) begin
            step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check($sformatf("reset%0d", i), 8'h10, 8'h80, 1'b0, 1'b0, 1'b0);
        end
        rst_x = 1'b0;
        step(255, 0, 0, 1, 0, 0);
        check("lat1", 8'h10, 8'h80, 1'b0, 1'b0, 1'b0);
        idle();
        check("lat2", 8'h10, 8'h80, 1'b0, 1'b0, 1'b0);
        idle();
        check("lat3", 8'h10, 8'h80, 1'b0, 1'b0, 1'b0);
        idle();
        check("lat4", 8'd82, 8'd90, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle();

        for (int i = 0; i < vq.size() + 3; i++) begin
            if (i < vq.size()) step(vq[i].r, vq[i].g, vq[i].b, vq[i].de, vq[i].hs, vq[i].vs);
            else idle();
            if (i >= 3)
                check($sformatf("vec%0d", i - 3), vq[i-3].y, vq[i-3].c, vq[i-3].de, vq[i-3].hs, vq[i-3].vs);
        end

        step(255, 0, 0, 1, 0, 0);
        step(0, 255, 0, 1, 0, 0);
        step(0, 0, 255, 1, 0, 0);
        rst_x = 1'b1;
        step(255, 0, 0, 1, 1, 1);
        check("midrst", 8'h10, 8'h80, 1'b0, 1'b0, 1'b0);
        rst_x = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            check($sformatf("stale%0d", i), 8'h10, 8'h80, 1'b0, 1'b0, 1'b0);
        end
        step(0, 0, 255, 1, 0, 0);
        step(0, 255, 0, 1, 0, 0);
        idle();
        idle();
        check("post_cb", 8'd41, 8'd240, 1'b1, 1'b0, 1'b0);
        idle();
        check("post_cr", 8'd144, 8'd110, 1'b1, 1'b0, 1'b0);
        idle();
        check("post_blank", 8'h10, 8'h80, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
